mult_datapath: RTL

// - Register/arithmetic datapath of the 8-bit signed shift-add multiplier.
// - Consumes Clr_Ld/Shift/Add/Sub from the multiplier control unit.
// - Feeds B back to control as its Bin operand.
// - Holds X (sign-extension bit), A (accumulator/product high) and B (multiplier/product low).
// - Computes A +/- S with a (WIDTH+1)-bit adder. S is the multiplicand from switches.
// - After one full control sequence: {A,B} = signed product, X = its sign.

---
 rtl/mult_datapath.sv | 108 ++++++++++
 1 files changed

// File: rtl/mult_datapath.sv
// rtl/mult_datapath.sv - register/arithmetic datapath of the signed shift-add multiplier
//
// Purpose: holds X (sign extension), A (accumulator / product high) and
// B (multiplier / product low). A single (WIDTH+1)-bit adder forms A+S or
// A-S. After a full control sequence {A,B} is the signed product and X its sign.
//
// Optional feature: define MULT_ZERO_FLAG_EN to add the registered Zero output.
//
// Ports:
//   Clk     in   1      clock, all state updates on posedge
//   Reset   in   1      synchronous active-high reset
//   Clr_Ld  in   1      A<=0, X<=0, B<=S
//   Shift   in   1      arithmetic right shift of {X,A,B}, X retained
//   Add     in   1      {X,A} <= sext(A) + sext(S)
//   Sub     in   1      {X,A} <= sext(A) - sext(S)
//   S       in   WIDTH  multiplicand / load value
//   Aval    out  WIDTH  A register
//   Bval    out  WIDTH  B register (control Bin operand)
//   X       out  1      sign-extension flip-flop
//   Zero    out  1      (MULT_ZERO_FLAG_EN only) registered all-zero flag

module mult_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Clr_Ld,
  input  logic             Shift,
  input  logic             Add,
  input  logic             Sub,
  input  logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X
`ifdef MULT_ZERO_FLAG_EN
  ,
  output logic             Zero
`endif
);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_x;

  logic [WIDTH-1:0] w_s_op;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_a_next;
  logic [WIDTH-1:0] w_b_next;
  logic             w_x_next;

  // One adder serves both operations: subtract inverts S and injects carry-in 1.
  // Sub is only the adder select when it is the winning operation, which is
  // exactly when it is used.
  assign w_s_op = Sub ? ~S : S;
  assign w_sum  = {r_a[WIDTH-1], r_a} + {w_s_op[WIDTH-1], w_s_op}
                + {{WIDTH{1'b0}}, Sub};

  // Next-state selection in priority order Clr_Ld > Sub > Add > Shift.
  always_comb begin
    w_a_next = r_a;
    w_b_next = r_b;
    w_x_next = r_x;
    if (Clr_Ld) begin
      w_a_next = '0;
      w_b_next = S;
      w_x_next = 1'b0;
    end else if (Sub || Add) begin
      // Bit WIDTH of the sign-extended sum is the true sign even on A overflow.
      w_a_next = w_sum[WIDTH-1:0];
      w_x_next = w_sum[WIDTH];
    end else if (Shift) begin
      w_a_next = {r_x, r_a[WIDTH-1:1]};
      w_b_next = {r_a[0], r_b[WIDTH-1:1]};
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_a <= '0;
      r_b <= '0;
      r_x <= 1'b0;
    end else begin
      r_a <= w_a_next;
      r_b <= w_b_next;
      r_x <= w_x_next;
    end
  end

  assign Aval = r_a;
  assign Bval = r_b;
  assign X    = r_x;

`ifdef MULT_ZERO_FLAG_EN
  logic r_zero;

  // Flag reflects the values the registers take at this same edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_zero <= 1'b1;
    end else begin
      r_zero <= (w_a_next == '0) && (w_b_next == '0) && !w_x_next;
    end
  end

  assign Zero = r_zero;
`endif

endmodule
